// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// the operands LSB first, one bit per clock, under a small IDLE/RUN/DONE FSM.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_x, fa_y, fa_s, fa_c;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        fa_x = a_q[idx_q];
        fa_y = b_q[idx_q];
        fa_s = fa_x ^ fa_y ^ carry_q;
        fa_c = (fa_x & fa_y) | (fa_x & carry_q) | (fa_y & carry_q);

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Subtract is a + ~b + 1, so the operand and carry are prepared here.
                    a_d     = a;
                    b_d     = op ? ~b : b;
                    carry_d = op ? 1'b1 : cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                sum_d[idx_q] = fa_s;
                carry_d      = fa_c;
                if (idx_q == LAST_IDX) begin
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d  = idx_q + IW'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): word-level reference model,
// expected results queued at stimulus time and popped when done pulses.
module tb_serial_add_ctrl;

    localparam int W = 8;
    localparam int MAX_WAIT = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    function automatic res_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic mop, logic mcin);
        logic [W-1:0] y;
        logic         c0;
        logic [W:0]   full;
        logic [W-1:0] low;
        res_t         r;
        y      = mop ? ~mb : mb;
        c0     = mop ? 1'b1 : mcin;
        full   = {1'b0, ma} + {1'b0, y} + {{W{1'b0}}, c0};
        low    = {1'b0, ma[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, c0};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = low[W-1] ^ full[W];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db, input logic dop,
                         input logic dcin, input logic push);
        a   = da;
        b   = db;
        op  = dop;
        cin = dcin;
        if (push) exp_q.push_back(model(da, db, dop, dcin));
    endtask

    task automatic compare_result(input string tag);
        res_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_sum"}, 32'(sum), 32'(e.sum));
        check({tag, "_cout"}, 32'(cout), 32'(e.cout));
        check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    endtask

    // Waits (on negedges) for done; reports negedges elapsed and busy samples seen.
    task automatic wait_done(input string tag, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end while (!done && lat < MAX_WAIT);
        if (!done) check({tag, "_timeout"}, 32'(lat), 32'(MAX_WAIT + 1));
    endtask

    // Single-pulse operation from IDLE: checks cleared partial sum, latency, busy length, result.
    task automatic single_op(input string tag, input logic [W-1:0] da, input logic [W-1:0] db,
                             input logic dop, input logic dcin);
        int lat, bc;
        drive(da, db, dop, dcin, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_clr_sum"}, 32'(sum), 32'd0);
        check({tag, "_busy0"}, 32'(busy), 32'd1);
        drive(~da, ~db, ~dop, ~dcin, 1'b0);
        wait_done(tag, lat, bc);
        check({tag, "_lat"}, 32'(lat + 1), 32'(W + 1));
        check({tag, "_busycnt"}, 32'(bc + 1), 32'(W));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        compare_result(tag);
    endtask

    initial begin
        res_t held;
        int   lat, bc;

        rst   = 1'b1;
        start = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_flags", 32'({cout, ovf, busy, done}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        single_op("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        held = model(8'hFF, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("hold_result", 32'({sum, cout, ovf}), 32'(held));

        single_op("7f_plus_01_c1", 8'h7F, 8'h01, 1'b0, 1'b1);
        single_op("05_minus_07", 8'h05, 8'h07, 1'b1, 1'b0);
        single_op("80_minus_01", 8'h80, 8'h01, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            single_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

        // Back-to-back: start held high, operands scrambled while RUN is busy.
        drive(8'h3C, 8'h55, 1'b0, 1'b1, 1'b1);
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                if (!done) drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end while (!done && lat < MAX_WAIT);
            check("b2b_lat", 32'(lat), 32'(W + 1));
            compare_result("b2b");
            if (k < 3) drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            else start = 1'b0;
        end
        @(negedge clk);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // Abort mid-RUN with a carry-heavy op; rst also collides with start.
        drive(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_flags", 32'({cout, ovf, busy, done}), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_over_start", 32'(busy), 32'd0);

        single_op("after_abort", 8'h01, 8'h02, 1'b0, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, meaning reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, meaning request to begin an operation; single-cycle pulse or level.
REQ-005 The block SHALL have port op, input, 1 bit, meaning operation select: 0 = add (a+b+cin), 1 = subtract (a-b).
REQ-006 The block SHALL have port a, input, WIDTH bits, meaning first operand, sampled only on an accepted start.
REQ-007 The block SHALL have port b, input, WIDTH bits, meaning second operand, sampled only on an accepted start.
REQ-008 The block SHALL have port cin, input, 1 bit, meaning carry-in for add, sampled on an accepted start and ignored for subtract.
REQ-009 The block SHALL have port sum, output, WIDTH bits, meaning the result register.
REQ-010 The block SHALL have port cout, output, 1 bit, meaning final carry out (for subtract, 1 = no borrow).
REQ-011 The block SHALL have port ovf, output, 1 bit, meaning two's-complement signed overflow of the result.
REQ-012 The block SHALL have port busy, output, 1 bit, meaning an operation is in progress.
REQ-013 The block SHALL have port done, output, 1 bit, meaning a one-cycle pulse indicating sum/cout/ovf are valid.

Function
REQ-014 The block SHALL compute the result bit-serially, LSB first, one bit per clock, through a single full-adder cell (s = x^y^c, c' = majority(x,y,c)) and a 1-bit carry register.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; reset state is IDLE.
REQ-016 In IDLE or DONE, start=1 SHALL be accepted: latch a, b (inverted when op=1) and the carry (cin when op=0, 1 when op=1); clear the bit index to 0; go to RUN.
REQ-017 In RUN, each cycle SHALL process bit index i: write sum[i], update the carry register, then increment i.
REQ-018 Bits of sum not yet processed SHALL be cleared to 0 on acceptance, so partial results are deterministic.
REQ-019 After bit WIDTH-1 is processed, the FSM SHALL go to DONE; cout takes the final carry; ovf = carry into MSB XOR carry out of MSB.
REQ-020 DONE SHALL last exactly one cycle, with done=1, then return to IDLE unless start=1 in that cycle (back-to-back operation: go directly to RUN).
REQ-021 Latency: if start is accepted at edge E0, done SHALL be high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles from start to done.
REQ-022 busy SHALL be 1 in RUN only, and 0 in IDLE and DONE.
REQ-023 start in RUN SHALL be ignored; a, b, cin and op SHALL have no effect on the operation in flight.
REQ-024 sum, cout and ovf SHALL hold their values from DONE until the next accepted start.
REQ-025 The bit index SHALL be ceil(log2(WIDTH)) bits wide or wider; the terminal compare SHALL be against WIDTH-1, with no wrap to 0 inside RUN.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, sum=0, cout=0, ovf=0, busy=0, done=0, and clear the carry and index, in any state including mid-RUN.
REQ-027 rst SHALL take priority over start in the same cycle, so no operation is accepted.

Verification (WIDTH=8)
REQ-028 a=FF, b=01, op=0, cin=0, start pulse -> done after 9 cycles; sum=00, cout=1, ovf=0; busy high for exactly 8 cycles.
REQ-029 a=7F, b=01, op=0, cin=1 -> sum=81, cout=0, ovf=1.
REQ-030 a=05, b=07, op=1 -> sum=FE, cout=0 (borrow), ovf=0; then a=80, b=01, op=1 -> sum=7F, cout=1, ovf=1.
REQ-031 Start held high continuously with new operands changed during RUN -> operands are taken only at acceptance; done pulses every 9 cycles; results are correct back-to-back.
REQ-032 rst asserted 3 cycles into RUN -> next cycle is IDLE with all outputs 0; a later start gives a correct full result, with no leftover carry.
